// File: rtl/quadrature_oscillator_mc.sv
// ---------------------------------------------------------------------------
// quadrature_oscillator_mc
//
// Multi-channel coupled-form quadrature oscillator. NCH channels share a
// single complex rotator that is time-multiplexed round-robin, one channel
// slot per clk while en is high. Each channel has its own run-time writable
// rotation coefficients, AGC power target and initial state.
//
// Optional feature macro: AGC_EN
//   defined   : amplitude control nudges each new sample towards the
//               channel's power target (adds the AGC_SHIFT parameter).
//   undefined : power writes are accepted but have no effect.
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   en         in   1 = slot counter advances and channels update
//   cfg_we     in   config write strobe
//   cfg_ch     in   config / start / stop target channel
//   cfg_sel    in   0 re_coeff, 1 im_coeff, 2 power, 3 init_re, 4 init_im
//   cfg_data   in   write data (coefficients use the low COEFF_W bits)
//   ch_start   in   load cfg_ch accumulators from init and set RUN
//   ch_stop    in   set cfg_ch IDLE, accumulators held
//   out_re     out  real part of the most recently updated channel
//   out_im     out  imaginary part of the most recently updated channel
//   out_ch     out  channel index of out_re/out_im
//   out_valid  out  one-cycle strobe, out_* freshly updated
//   running    out  per-channel RUN flags
// ---------------------------------------------------------------------------
module quadrature_oscillator_mc #(
  parameter int WIDTH   = 8,
  parameter int COEFF_W = 8,
  parameter int NCH     = 4,
`ifdef AGC_EN
  parameter int AGC_SHIFT = 4,
`endif
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    cfg_we,
  input  logic [CW-1:0]           cfg_ch,
  input  logic [2:0]              cfg_sel,
  input  logic [WIDTH-1:0]        cfg_data,
  input  logic                    ch_start,
  input  logic                    ch_stop,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic [CW-1:0]           out_ch,
  output logic                    out_valid,
  output logic [NCH-1:0]          running
);

  typedef enum logic [2:0] {
    FIELD_RE_COEFF = 3'd0,
    FIELD_IM_COEFF = 3'd1,
    FIELD_POWER    = 3'd2,
    FIELD_INIT_RE  = 3'd3,
    FIELD_INIT_IM  = 3'd4
  } cfg_field_e;

  // Rotation products are kept at full precision: one extra bit covers the
  // sum of two products plus the rounding constant.
  localparam int PW = WIDTH + COEFF_W + 1;
  localparam logic signed [PW-1:0] RND     = PW'(2 ** (COEFF_W - 2));
  localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = PW'(-(2 ** (WIDTH - 1)));
  localparam logic [CW:0]          NCH_LIM = (CW + 1)'(NCH);
  localparam logic [CW-1:0]        SLOT_LAST = CW'(NCH - 1);

  logic signed [WIDTH-1:0]   re_acc   [NCH];
  logic signed [WIDTH-1:0]   im_acc   [NCH];
  logic signed [WIDTH-1:0]   init_re  [NCH];
  logic signed [WIDTH-1:0]   init_im  [NCH];
  logic signed [COEFF_W-1:0] re_coeff [NCH];
  logic signed [COEFF_W-1:0] im_coeff [NCH];
`ifdef AGC_EN
  logic [WIDTH-1:0]          power    [NCH];
`endif
  logic [CW-1:0]             slot;

  logic                      cfg_ok;
  logic                      slot_hit;
  logic                      start_ok;
  logic                      stop_ok;
  logic                      do_update;

  logic signed [WIDTH-1:0]   cur_re;
  logic signed [WIDTH-1:0]   cur_im;
  logic signed [COEFF_W-1:0] cur_c;
  logic signed [COEFF_W-1:0] cur_d;
  logic signed [PW-1:0]      prod_re;
  logic signed [PW-1:0]      prod_im;
  logic signed [WIDTH-1:0]   rot_re;
  logic signed [WIDTH-1:0]   rot_im;
  logic signed [WIDTH-1:0]   next_re;
  logic signed [WIDTH-1:0]   next_im;

  function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] sh;
    sh = v >>> (COEFF_W - 1);
    if (sh > SAT_MAX)      round_sat = WIDTH'(SAT_MAX);
    else if (sh < SAT_MIN) round_sat = WIDTH'(SAT_MIN);
    else                   round_sat = WIDTH'(sh);
  endfunction

  // Out-of-range channel numbers make write/start/stop a no-op. Stop beats
  // start, and either strobe aimed at the channel owning the current slot
  // suppresses that slot's rotation.
  assign cfg_ok    = ({1'b0, cfg_ch} < NCH_LIM);
  assign slot_hit  = cfg_ok && (cfg_ch == slot);
  assign start_ok  = cfg_ok && ch_start && !ch_stop;
  assign stop_ok   = cfg_ok && ch_stop;
  assign do_update = en && running[slot] && !(slot_hit && (ch_start || ch_stop));

  always_comb begin
    cur_re  = re_acc[slot];
    cur_im  = im_acc[slot];
    cur_c   = re_coeff[slot];
    cur_d   = im_coeff[slot];
    prod_re = PW'(cur_re) * PW'(cur_c) - PW'(cur_im) * PW'(cur_d) + RND;
    prod_im = PW'(cur_im) * PW'(cur_c) + PW'(cur_re) * PW'(cur_d) + RND;
    rot_re  = round_sat(prod_re);
    rot_im  = round_sat(prod_im);
  end

`ifdef AGC_EN
  localparam int AW  = WIDTH + 2;
  localparam int SQW = 2 * WIDTH + 2;
  localparam logic signed [AW-1:0]  AGC_MAX = AW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [AW-1:0]  AGC_MIN = AW'(-(2 ** (WIDTH - 1)));
  // Squared magnitude at or above this value saturates the scaled power.
  localparam logic signed [SQW-1:0] P_LIM   = SQW'(1) <<< (2 * WIDTH - 1);

  logic signed [SQW-1:0] mag_sq;
  logic [WIDTH-1:0]      mag_p;

  function automatic logic signed [WIDTH-1:0] agc_adjust(input logic signed [WIDTH-1:0] v,
                                                         input logic up);
    logic signed [AW-1:0] x;
    logic signed [AW-1:0] r;
    x = AW'(v);
    r = up ? (x + (x >>> AGC_SHIFT)) : (x - (x >>> AGC_SHIFT));
    if (r > AGC_MAX)      agc_adjust = WIDTH'(AGC_MAX);
    else if (r < AGC_MIN) agc_adjust = WIDTH'(AGC_MIN);
    else                  agc_adjust = WIDTH'(r);
  endfunction

  // Power estimate uses the pre-rotation state; the correction is applied to
  // the freshly rotated sample.
  always_comb begin
    mag_sq  = SQW'(cur_re) * SQW'(cur_re) + SQW'(cur_im) * SQW'(cur_im);
    mag_p   = (mag_sq >= P_LIM) ? '1 : WIDTH'(mag_sq >>> (WIDTH - 1));
    next_re = rot_re;
    next_im = rot_im;
    if (mag_p < power[slot]) begin
      next_re = agc_adjust(rot_re, 1'b1);
      next_im = agc_adjust(rot_im, 1'b1);
    end else if (mag_p > power[slot]) begin
      next_re = agc_adjust(rot_re, 1'b0);
      next_im = agc_adjust(rot_im, 1'b0);
    end
  end
`else
  assign next_re = rot_re;
  assign next_im = rot_im;
`endif

  // Slot counter, channel state and output registers. A start on a channel
  // never coincides with that channel's rotation write because the rotation
  // is suppressed in that case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot      <= '0;
      running   <= '0;
      out_re    <= '0;
      out_im    <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        re_acc[i]   <= '0;
        im_acc[i]   <= '0;
        init_re[i]  <= '0;
        init_im[i]  <= '0;
        re_coeff[i] <= '0;
        im_coeff[i] <= '0;
`ifdef AGC_EN
        power[i]    <= '0;
`endif
      end
    end else begin
      if (en) begin
        slot <= (slot == SLOT_LAST) ? '0 : slot + CW'(1);
      end

      out_valid <= do_update;
      if (do_update) begin
        re_acc[slot] <= next_re;
        im_acc[slot] <= next_im;
        out_re       <= next_re;
        out_im       <= next_im;
        out_ch       <= slot;
      end

      if (cfg_we && cfg_ok) begin
        case (cfg_sel)
          FIELD_RE_COEFF: re_coeff[cfg_ch] <= cfg_data[COEFF_W-1:0];
          FIELD_IM_COEFF: im_coeff[cfg_ch] <= cfg_data[COEFF_W-1:0];
`ifdef AGC_EN
          FIELD_POWER:    power[cfg_ch]    <= cfg_data;
`endif
          FIELD_INIT_RE:  init_re[cfg_ch]  <= cfg_data;
          FIELD_INIT_IM:  init_im[cfg_ch]  <= cfg_data;
          default: ;
        endcase
      end

      if (start_ok) begin
        re_acc[cfg_ch]  <= init_re[cfg_ch];
        im_acc[cfg_ch]  <= init_im[cfg_ch];
        running[cfg_ch] <= 1'b1;
      end
      if (stop_ok) begin
        running[cfg_ch] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_oscillator_mc.sv
// ---------------------------------------------------------------------------
// tb_quadrature_oscillator_mc
//
// Self-checking bench for quadrature_oscillator_mc (WIDTH=8, COEFF_W=8,
// NCH=4). A behavioural model tracks every channel with plain integer
// arithmetic (floor division, clamping) and predicts the outputs after each
// clock; directed scenarios also check hand-computed constants.
// ---------------------------------------------------------------------------
module tb_quadrature_oscillator_mc;

  localparam int WIDTH   = 8;
  localparam int COEFF_W = 8;
  localparam int NCH     = 4;
  localparam int CW      = 2;
  localparam int SCALE   = 1 << (COEFF_W - 1);
  localparam int HALF    = 1 << (COEFF_W - 2);
  localparam int VMAX    = (1 << (WIDTH - 1)) - 1;
  localparam int VMIN    = -(1 << (WIDTH - 1));

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    en;
  logic                    cfg_we;
  logic [CW-1:0]           cfg_ch;
  logic [2:0]              cfg_sel;
  logic [WIDTH-1:0]        cfg_data;
  logic                    ch_start;
  logic                    ch_stop;
  logic signed [WIDTH-1:0] out_re;
  logic signed [WIDTH-1:0] out_im;
  logic [CW-1:0]           out_ch;
  logic                    out_valid;
  logic [NCH-1:0]          running;

  always #5 clk = ~clk;

  quadrature_oscillator_mc #(
    .WIDTH   (WIDTH),
    .COEFF_W (COEFF_W),
    .NCH     (NCH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .ch_start  (ch_start),
    .ch_stop   (ch_stop),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .running   (running)
  );

  // Behavioural model state
  int m_re [NCH];
  int m_im [NCH];
  int m_c  [NCH];
  int m_d  [NCH];
  int m_pw [NCH];
  int m_ir [NCH];
  int m_ii [NCH];
  bit m_run[NCH];
  int m_slot;
  int e_re;
  int e_im;
  int e_ch;
  bit e_valid;

  int n_cmp;
  int n_bad;

  function automatic int to_signed(int v, int bits);
    int m;
    m = v & ((1 << bits) - 1);
    return (m >= (1 << (bits - 1))) ? m - (1 << bits) : m;
  endfunction

  function automatic int floor_div(int num, int den);
    int q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int clamp(int v);
    if (v > VMAX) return VMAX;
    if (v < VMIN) return VMIN;
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_running();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = m_run[i];
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_re[i] = 0; m_im[i] = 0; m_c[i] = 0; m_d[i] = 0;
      m_pw[i] = 0; m_ir[i] = 0; m_ii[i] = 0; m_run[i] = 0;
    end
    m_slot  = 0;
    e_re    = 0;
    e_im    = 0;
    e_ch    = 0;
    e_valid = 0;
  endfunction

  // One clock of the oscillator bank, evaluated from the inputs present at
  // the rising edge.
  function automatic void model_step();
    int s;
    int ch;
    bit ok;
    bit hit;
    int nr;
    int ni;
    int p;
    s   = m_slot;
    ch  = int'(cfg_ch);
    ok  = (ch < NCH);
    hit = ok && (ch == s) && (ch_start || ch_stop);
    e_valid = 0;
    if (en && m_run[s] && !hit) begin
      nr = clamp(floor_div(m_re[s] * m_c[s] - m_im[s] * m_d[s] + HALF, SCALE));
      ni = clamp(floor_div(m_im[s] * m_c[s] + m_re[s] * m_d[s] + HALF, SCALE));
`ifdef AGC_EN
      p = (m_re[s] * m_re[s] + m_im[s] * m_im[s]) / (1 << (WIDTH - 1));
      if (p > (1 << WIDTH) - 1) p = (1 << WIDTH) - 1;
      if (p < m_pw[s]) begin
        nr = clamp(nr + floor_div(nr, 16));
        ni = clamp(ni + floor_div(ni, 16));
      end else if (p > m_pw[s]) begin
        nr = clamp(nr - floor_div(nr, 16));
        ni = clamp(ni - floor_div(ni, 16));
      end
`else
      p = 0;
`endif
      m_re[s] = nr;
      m_im[s] = ni;
      e_re    = nr;
      e_im    = ni;
      e_ch    = s;
      e_valid = 1;
    end
    if (ok && ch_start && !ch_stop) begin
      m_re[ch]  = m_ir[ch];
      m_im[ch]  = m_ii[ch];
      m_run[ch] = 1;
    end
    if (ok && ch_stop) m_run[ch] = 0;
    if (ok && cfg_we) begin
      case (int'(cfg_sel))
        0: m_c[ch]  = to_signed(int'(cfg_data), COEFF_W);
        1: m_d[ch]  = to_signed(int'(cfg_data), COEFF_W);
        2: m_pw[ch] = int'(cfg_data);
        3: m_ir[ch] = to_signed(int'(cfg_data), WIDTH);
        4: m_ii[ch] = to_signed(int'(cfg_data), WIDTH);
        default: ;
      endcase
    end
    if (en) m_slot = (m_slot + 1) % NCH;
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    cfg_we   = 1'b0;
    ch_start = 1'b0;
    ch_stop  = 1'b0;
    cfg_sel  = 3'd0;
    cfg_data = '0;
    cfg_ch   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    en    = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic write_cfg(int ch, int sel, int data);
    cfg_we   = 1'b1;
    cfg_ch   = CW'(ch);
    cfg_sel  = 3'(sel);
    cfg_data = WIDTH'(data);
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic configure(int ch, int c, int d, int pw, int ir, int ii);
    write_cfg(ch, 0, c);
    write_cfg(ch, 1, d);
    write_cfg(ch, 2, pw);
    write_cfg(ch, 3, ir);
    write_cfg(ch, 4, ii);
  endtask

  task automatic start_ch(int ch);
    cfg_ch   = CW'(ch);
    ch_start = 1'b1;
    step();
    ch_start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    en    = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    n_cmp++; if (out_re !== '0)    begin n_bad++; $display("[TB] FAIL reset_out_re: got %0d expected 0", out_re); end
    n_cmp++; if (out_im !== '0)    begin n_bad++; $display("[TB] FAIL reset_out_im: got %0d expected 0", out_im); end
    n_cmp++; if (out_ch !== '0)    begin n_bad++; $display("[TB] FAIL reset_out_ch: got %0d expected 0", out_ch); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (running !== '0)   begin n_bad++; $display("[TB] FAIL reset_running: got %b expected 0", running); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic_vector();
    int want_re;
    do_reset();
    configure(0, 'h7d, 'h1b, 'h40, 'h20, 'h00);
    start_ch(0);
    en = 1'b1;
    step();
`ifdef AGC_EN
    want_re = 32;
`else
    want_re = 31;
`endif
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_ch !== CW'(0))  begin n_bad++; $display("[TB] FAIL basic_ch: got %0d expected 0", out_ch); end
    n_cmp++; if (out_re !== WIDTH'(want_re)) begin n_bad++; $display("[TB] FAIL basic_re: got %0d expected %0d", out_re, want_re); end
    n_cmp++; if (out_im !== WIDTH'(7)) begin n_bad++; $display("[TB] FAIL basic_im: got %0d expected 7", out_im); end
    for (int i = 0; i < NCH - 1; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_idle_valid: got %b expected 0", out_valid); end
      n_cmp++; if (out_re !== WIDTH'(want_re)) begin n_bad++; $display("[TB] FAIL basic_hold_re: got %0d expected %0d", out_re, want_re); end
    end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_second_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_re !== WIDTH'(e_re)) begin n_bad++; $display("[TB] FAIL basic_second_re: got %0d expected %0d", out_re, e_re); end
    n_cmp++; if (out_im !== WIDTH'(e_im)) begin n_bad++; $display("[TB] FAIL basic_second_im: got %0d expected %0d", out_im, e_im); end
  endtask

  task automatic test_saturation();
    do_reset();
    // Power target equals the pre-rotation power (252) so AGC leaves it alone.
    configure(0, 'h7f, 'h7f, 'hfc, 'h7f, 'h7f);
    start_ch(0);
    en = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL sat_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_re !== WIDTH'(0))   begin n_bad++; $display("[TB] FAIL sat_re: got %0d expected 0", out_re); end
    n_cmp++; if (out_im !== WIDTH'(127)) begin n_bad++; $display("[TB] FAIL sat_im: got %0d expected 127", out_im); end
  endtask

  task automatic test_pattern();
    int hold_re;
    do_reset();
    configure(0, 'h7d, 'h1b, 'h40, 'h20, 'h00);
    configure(2, 'h70, 'hc0, 'h20, 'h10, 'h30);
    start_ch(0);
    start_ch(2);
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++; if (out_valid !== ((i % 2) == 0)) begin n_bad++; $display("[TB] FAIL pattern_valid[%0d]: got %b expected %b", i, out_valid, (i % 2) == 0); end
      n_cmp++; if (out_ch !== CW'(((i / 2) % 2 == 0) ? 0 : 2)) begin n_bad++; $display("[TB] FAIL pattern_ch[%0d]: got %0d expected %0d", i, out_ch, ((i / 2) % 2 == 0) ? 0 : 2); end
      n_cmp++; if (out_re !== WIDTH'(e_re)) begin n_bad++; $display("[TB] FAIL pattern_re[%0d]: got %0d expected %0d", i, out_re, e_re); end
      n_cmp++; if (out_im !== WIDTH'(e_im)) begin n_bad++; $display("[TB] FAIL pattern_im[%0d]: got %0d expected %0d", i, out_im, e_im); end
    end
    hold_re = e_re;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL freeze_valid[%0d]: got %b expected 0", i, out_valid); end
      n_cmp++; if (out_re !== WIDTH'(hold_re)) begin n_bad++; $display("[TB] FAIL freeze_re[%0d]: got %0d expected %0d", i, out_re, hold_re); end
      n_cmp++; if (running !== 4'b0101) begin n_bad++; $display("[TB] FAIL freeze_running[%0d]: got %b expected 0101", i, running); end
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (out_valid !== ((i % 2) == 0)) begin n_bad++; $display("[TB] FAIL resume_valid[%0d]: got %b expected %b", i, out_valid, (i % 2) == 0); end
      n_cmp++; if (out_re !== WIDTH'(e_re)) begin n_bad++; $display("[TB] FAIL resume_re[%0d]: got %0d expected %0d", i, out_re, e_re); end
    end
  endtask

  task automatic test_start_on_slot();
    int want_re;
`ifdef AGC_EN
    want_re = 32;
`else
    want_re = 31;
`endif
    do_reset();
    configure(1, 'h7d, 'h1b, 'h40, 'h20, 'h00);
    en = 1'b1;
    step();
    cfg_ch   = CW'(1);
    ch_start = 1'b1;
    step();
    ch_start = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL coincide_valid: got %b expected 0", out_valid); end
    n_cmp++; if (running !== 4'b0010) begin n_bad++; $display("[TB] FAIL coincide_running: got %b expected 0010", running); end
    for (int i = 0; i < NCH - 1; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL coincide_gap_valid[%0d]: got %b expected 0", i, out_valid); end
    end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL coincide_next_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_ch !== CW'(1))  begin n_bad++; $display("[TB] FAIL coincide_next_ch: got %0d expected 1", out_ch); end
    n_cmp++; if (out_re !== WIDTH'(want_re)) begin n_bad++; $display("[TB] FAIL coincide_next_re: got %0d expected %0d", out_re, want_re); end
    n_cmp++; if (out_im !== WIDTH'(7)) begin n_bad++; $display("[TB] FAIL coincide_next_im: got %0d expected 7", out_im); end
  endtask

  task automatic test_stop_cases();
    do_reset();
    configure(3, 'h60, 'h20, 'h30, 'h40, 'hf0);
    start_ch(3);
    en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    cfg_ch  = CW'(3);
    ch_stop = 1'b1;
    step();
    ch_stop = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL stop_slot_valid: got %b expected 0", out_valid); end
    n_cmp++; if (running !== 4'b0000) begin n_bad++; $display("[TB] FAIL stop_slot_running: got %b expected 0000", running); end
    cfg_ch   = CW'(3);
    ch_start = 1'b1;
    ch_stop  = 1'b1;
    step();
    ch_start = 1'b0;
    ch_stop  = 1'b0;
    n_cmp++; if (running !== 4'b0000) begin n_bad++; $display("[TB] FAIL start_stop_running: got %b expected 0000", running); end
    for (int i = 0; i < NCH; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL stopped_valid[%0d]: got %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom % 4) != 0;
      cfg_ch   = CW'($urandom % NCH);
      ch_start = ($urandom % 8) == 0;
      ch_stop  = ($urandom % 16) == 0;
      cfg_we   = !ch_start && (($urandom % 2) == 0);
      cfg_sel  = 3'($urandom % 8);
      cfg_data = WIDTH'($urandom);
      step();
      n_cmp++; if (out_valid !== e_valid) begin n_bad++; $display("[TB] FAIL rand_valid[%0d]: got %b expected %b", i, out_valid, e_valid); end
      n_cmp++; if (out_ch !== CW'(e_ch))  begin n_bad++; $display("[TB] FAIL rand_ch[%0d]: got %0d expected %0d", i, out_ch, e_ch); end
      n_cmp++; if (out_re !== WIDTH'(e_re)) begin n_bad++; $display("[TB] FAIL rand_re[%0d]: got %0d expected %0d", i, out_re, e_re); end
      n_cmp++; if (out_im !== WIDTH'(e_im)) begin n_bad++; $display("[TB] FAIL rand_im[%0d]: got %0d expected %0d", i, out_im, e_im); end
      n_cmp++; if (running !== exp_running()) begin n_bad++; $display("[TB] FAIL rand_running[%0d]: got %b expected %b", i, running, exp_running()); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midrun();
    do_reset();
    configure(0, 'h7d, 'h1b, 'h40, 'h20, 'h00);
    configure(1, 'h70, 'h30, 'h40, 'h50, 'h10);
    start_ch(0);
    start_ch(1);
    en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL midrun_pre_valid: got %b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midrun_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_re !== '0)      begin n_bad++; $display("[TB] FAIL midrun_re: got %0d expected 0", out_re); end
    n_cmp++; if (out_im !== '0)      begin n_bad++; $display("[TB] FAIL midrun_im: got %0d expected 0", out_im); end
    n_cmp++; if (out_ch !== '0)      begin n_bad++; $display("[TB] FAIL midrun_ch: got %0d expected 0", out_ch); end
    n_cmp++; if (running !== '0)     begin n_bad++; $display("[TB] FAIL midrun_running: got %b expected 0", running); end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL post_reset_valid[%0d]: got %b expected 0", i, out_valid); end
      n_cmp++; if (running !== '0)     begin n_bad++; $display("[TB] FAIL post_reset_running[%0d]: got %b expected 0", i, running); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    $display("[TB] quadrature_oscillator_mc bench starting");
    test_reset();
    test_basic_vector();
    test_saturation();
    test_pattern();
    test_start_on_slot();
    test_stop_cases();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
